// File: rtl/sha_pkg.sv
// sha_pkg: shared types and constants for the SHA-256 padded-block unpadder.
//   - unpad_state_t : FSM states of sha_unpadder
//   - block geometry constants (block size, length field, message limit)
//   - block_byte()  : extracts byte k (0 = most significant) of a padded block
package sha_pkg;

    localparam int unsigned PADDED_SIZE     = 512;
    localparam int unsigned WORDS_PER_BLOCK = 16;
    localparam int unsigned LEN_FIELD_BITS  = 64;
    localparam int unsigned BLOCK_BYTES     = PADDED_SIZE / 8;
    // Marker byte plus 8-byte length field leave this many message bytes.
    localparam int unsigned MAX_MSG_BYTES   = BLOCK_BYTES - LEN_FIELD_BITS / 8 - 1;
    localparam logic [7:0]  PAD_MARKER      = 8'h80;
    localparam int unsigned BCNT_W          = 6;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_CHECK,
        ST_EMIT,
        ST_FIN
    } unpad_state_t;

    function automatic logic [7:0] block_byte(input logic [PADDED_SIZE-1:0] blk,
                                              input int unsigned             k);
        logic [PADDED_SIZE-1:0] sh;
        sh = blk >> (8 * (BLOCK_BYTES - 1 - k));
        return sh[7:0];
    endfunction

endpackage

// File: rtl/sha_unpadder_if.sv
// sha_unpadder_if: stream bundle between a padded-word producer / byte consumer
// and sha_unpadder.
//   in_word/in_valid/in_ready/in_last : padded 32-bit word stream into the unpadder
//   out_byte/out_valid/out_ready/out_last : recovered message byte stream
//   msg_len_bits : length field of the last checked block
//   done/err     : end-of-block pulse and padding/framing verdict
//   slave  modport: the unpadder side
//   master modport: the environment side (word source and byte sink)
interface sha_unpadder_if;

    logic [31:0]                        in_word;
    logic                               in_valid;
    logic                               in_ready;
    logic                               in_last;
    logic [7:0]                         out_byte;
    logic                               out_valid;
    logic                               out_ready;
    logic                               out_last;
    logic [sha_pkg::LEN_FIELD_BITS-1:0] msg_len_bits;
    logic                               done;
    logic                               err;

    modport slave (
        input  in_word, in_valid, in_last, out_ready,
        output in_ready, out_byte, out_valid, out_last, msg_len_bits, done, err
    );

    modport master (
        output in_word, in_valid, in_last, out_ready,
        input  in_ready, out_byte, out_valid, out_last, msg_len_bits, done, err
    );

endinterface

// File: rtl/sha_pad_checker.sv
// sha_pad_checker: combinational padding validator for one 512-bit block.
//   block_i  : the block, byte 0 in the most significant bits
//   pad_ok_o : length byte-aligned and in range, marker at byte n, zero fill after it
//   n_o      : message length in bytes (meaningful only when pad_ok_o is 1)
//   len_o    : the raw 64-bit big-endian length field
module sha_pad_checker
    import sha_pkg::*;
(
    input  logic [PADDED_SIZE-1:0]    block_i,
    output logic                      pad_ok_o,
    output logic [BCNT_W-1:0]         n_o,
    output logic [LEN_FIELD_BITS-1:0] len_o
);

    logic [LEN_FIELD_BITS-1:0] len;
    logic [BCNT_W-1:0]         n;
    logic                      len_ok;
    logic                      bytes_ok;

    assign len   = block_i[LEN_FIELD_BITS-1:0];
    // Truncation is harmless: any length that does not fit fails len_ok.
    assign n     = len[BCNT_W+2:3];
    assign len_o = len;
    assign n_o   = n;

    always_comb begin
        len_ok   = (len[2:0] == 3'b000) && (len <= 64'(8 * MAX_MSG_BYTES));
        bytes_ok = 1'b1;
        for (int unsigned k = 0; k <= MAX_MSG_BYTES; k++) begin
            if (k == 32'(n)) begin
                if (block_byte(block_i, k) != PAD_MARKER) begin
                    bytes_ok = 1'b0;
                end
            end else if (k > 32'(n)) begin
                if (block_byte(block_i, k) != 8'h00) begin
                    bytes_ok = 1'b0;
                end
            end
        end
        pad_ok_o = len_ok && bytes_ok;
    end

endmodule

// File: rtl/sha_unpadder.sv
// sha_unpadder: collects one padded SHA-256 block (16 x 32-bit words), validates
// its padding and replays the original message as a byte stream, MSB first.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : sha_unpadder_if.slave -- word input stream, byte output stream,
//         msg_len_bits, done pulse and err verdict
module sha_unpadder
    import sha_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    sha_unpadder_if.slave  bus
);

    unpad_state_t              state_q, state_d;
    logic [3:0]                wcnt_q, wcnt_d;
    logic [BCNT_W-1:0]         bcnt_q, bcnt_d;
    logic [BCNT_W-1:0]         n_q, n_d;
    logic                      err_q, err_d;
    logic [LEN_FIELD_BITS-1:0] len_q, len_d;
    // Holds in_ready low through reset and lifts it on the first edge after release.
    logic                      armed_q;

    logic [31:0]               buf_q [WORDS_PER_BLOCK];
    logic [PADDED_SIZE-1:0]    block;

    logic                      pad_ok;
    logic [BCNT_W-1:0]         chk_n;
    logic [LEN_FIELD_BITS-1:0] chk_len;

    logic                      in_ready;
    logic                      in_fire;
    logic                      out_valid;
    logic                      out_fire;

    assign in_ready  = armed_q && (state_q == ST_COLLECT);
    assign in_fire   = bus.in_valid && in_ready;
    assign out_valid = (state_q == ST_EMIT);
    assign out_fire  = out_valid && bus.out_ready;

    // Word buffer: deliberately not reset, only written on accepted words.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_q[wcnt_q] <= bus.in_word;
        end
    end

    always_comb begin
        block = '0;
        for (int unsigned i = 0; i < WORDS_PER_BLOCK; i++) begin
            block[PADDED_SIZE-1-32*i -: 32] = buf_q[i];
        end
    end

    sha_pad_checker u_checker (
        .block_i  (block),
        .pad_ok_o (pad_ok),
        .n_o      (chk_n),
        .len_o    (chk_len)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_COLLECT;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            n_q     <= '0;
            err_q   <= 1'b0;
            len_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            n_q     <= n_d;
            err_q   <= err_d;
            len_q   <= len_d;
            armed_q <= 1'b1;
        end
    end

    // The verdict register only changes on entry to FIN, so err stays valid
    // from one done pulse to the next.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        n_d     = n_q;
        err_d   = err_q;
        len_d   = len_q;
        unique case (state_q)
            ST_COLLECT: begin
                if (in_fire) begin
                    wcnt_d = wcnt_q + 4'd1;
                    if (wcnt_q == 4'd15) begin
                        if (bus.in_last) begin
                            state_d = ST_CHECK;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_FIN;
                        end
                    end else if (bus.in_last) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end
                end
            end
            ST_CHECK: begin
                len_d  = chk_len;
                n_d    = chk_n;
                bcnt_d = '0;
                if (!pad_ok) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else if (chk_n == '0) begin
                    err_d   = 1'b0;
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_fire) begin
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == n_q - 1'b1) begin
                        err_d   = 1'b0;
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                wcnt_d  = '0;
                state_d = ST_COLLECT;
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_byte     = out_valid ? block_byte(block, 32'(bcnt_q)) : 8'h00;
    assign bus.out_last     = out_valid && (bcnt_q == n_q - 1'b1);
    assign bus.done         = (state_q == ST_FIN);
    assign bus.err          = err_q;
    // The length becomes visible combinationally during CHECK, then from the register.
    assign bus.msg_len_bits = (state_q == ST_CHECK) ? chk_len : len_q;

endmodule

// File: tb/tb_sha_unpadder.sv
module tb_sha_unpadder;

    typedef logic [31:0] blk_t [16];
    typedef struct {
        blk_t        w;
        int          last_at;
        bit          exp_err;
        int          exp_n;
        bit          chk_len;
        logic [63:0] exp_len;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    sha_unpadder_if bus ();

    sha_unpadder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rmode  = 0;

    int          cyc = 0;
    int          last_in_cyc = 0;
    int          first_out_cyc = -1;
    int          last_byte_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    bit          done_err;
    logic [63:0] done_len;
    bit          saw_valid;
    logic [7:0]  got_bytes [$];
    bit          got_last  [$];
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_byte;
    logic        prev_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, half a cycle from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) last_in_cyc = cyc;
            if (bus.out_valid) begin
                saw_valid = 1'b1;
                if (first_out_cyc < 0) first_out_cyc = cyc;
            end
            if (prev_stall) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_byte", bus.out_byte, prev_byte);
                check("stall_last", bus.out_last, prev_last);
            end
            if (bus.out_valid && bus.out_ready) begin
                got_bytes.push_back(bus.out_byte);
                got_last.push_back(bus.out_last);
                last_byte_cyc = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                done_err = bus.err;
                done_len = bus.msg_len_bits;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_byte  = bus.out_byte;
            prev_last  = bus.out_last;
        end
    end

    // Downstream ready pattern: 0 always ready, 1 toggle, 2 random, 3 never ready.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = !bus.out_ready;
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] byte_at(input blk_t w, input int k);
        return 8'(w[k/4] >> (8 * (3 - k % 4)));
    endfunction

    // Reference: framing first, then the padding rules on the byte view of the block.
    function automatic void model(input blk_t w, input int last_at, output bit err, output int n);
        logic [63:0] L;
        bit ok;
        n = 0;
        if (last_at != 15) begin
            err = 1'b1;
            return;
        end
        L  = {w[14], w[15]};
        ok = (L % 8 == 0) && (L <= 64'd440);
        if (ok) begin
            n = int'(L / 8);
            if (byte_at(w, n) != 8'h80) ok = 1'b0;
            for (int k = n + 1; k < 56; k++)
                if (byte_at(w, k) != 8'h00) ok = 1'b0;
        end
        err = !ok;
        if (!ok) n = 0;
    endfunction

    function automatic vec_t mk(input blk_t w, input int last_at, input bit e, input int n,
                                input bit cl, input logic [63:0] len);
        vec_t v;
        v.w = w; v.last_at = last_at; v.exp_err = e; v.exp_n = n;
        v.chk_len = cl; v.exp_len = len;
        return v;
    endfunction

    task automatic send_words(input blk_t w, input int last_at, input bit gaps);
        int nsend;
        int g;
        bit rdy;
        nsend = (last_at < 16) ? last_at + 1 : 16;
        for (int i = 0; i < nsend; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.in_word  = w[i];
            bus.in_valid = 1'b1;
            bus.in_last  = (i == last_at);
            g = 0;
            do begin
                rdy = bus.in_ready;
                @(posedge clk);
                #1;
                g++;
            end while (!rdy && g < 64);
            if (!rdy) check("in_ready_timeout", 0, 1);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_last"}, bus.out_last, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_out_byte"}, bus.out_byte, 0);
        check({tag, "_msg_len"}, bus.msg_len_bits, 0);
    endtask

    task automatic run_block(input string tag, input blk_t w, input int last_at, input bit exp_err,
                             input int exp_n, input bit chk_len, input logic [63:0] exp_len,
                             input bit gaps);
        int d0;
        int g;
        longint unsigned got_mask;
        longint unsigned exp_mask;
        got_bytes.delete();
        got_last.delete();
        saw_valid     = 1'b0;
        first_out_cyc = -1;
        d0            = done_cnt;
        send_words(w, last_at, gaps);
        g = 0;
        while (done_cnt == d0 && g < 400) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (done_cnt == d0) begin
            check({tag, "_done_timeout"}, 0, 1);
            return;
        end
        check({tag, "_err"}, done_err, exp_err);
        check({tag, "_nbytes"}, got_bytes.size(), exp_n);
        for (int k = 0; k < got_bytes.size() && k < exp_n; k++)
            check($sformatf("%s_byte%0d", tag, k), got_bytes[k], byte_at(w, k));
        got_mask = 0;
        for (int k = 0; k < got_last.size(); k++)
            if (got_last[k]) got_mask |= longint'(1) << k;
        exp_mask = (exp_n > 0) ? (longint'(1) << (exp_n - 1)) : 0;
        check({tag, "_last_pos"}, got_mask, exp_mask);
        if (exp_n == 0) begin
            check({tag, "_no_valid"}, saw_valid, 0);
            check({tag, "_done_lat"}, done_cyc - last_in_cyc, (last_at == 15) ? 2 : 1);
        end else begin
            check({tag, "_first_lat"}, first_out_cyc - last_in_cyc, 2);
            check({tag, "_done_after_last"}, done_cyc - last_byte_cyc, 1);
        end
        if (chk_len) check({tag, "_msg_len"}, done_len, exp_len);
        @(posedge clk);
        #1;
        check({tag, "_err_hold"}, bus.err, exp_err);
        check({tag, "_done_pulse"}, bus.done, 0);
    endtask

    initial begin
        vec_t        tbl [10];
        blk_t        abc, t, e;
        logic [7:0]  b [64];
        logic [63:0] L;
        int          n, last_at, c, m, d0, g;
        bit          er;

        rst          = 1'b0;
        bus.in_word  = '0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        for (int i = 0; i < 16; i++) begin abc[i] = '0; e[i] = '0; end
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;
        e[0]    = 32'h80000000;

        tbl[0] = mk(abc, 15, 0, 3, 1, 64'd24);
        tbl[1] = mk(e,   15, 0, 0, 1, 64'd0);
        t = abc; t[15] = 32'h17;       tbl[2] = mk(t, 15, 1, 0, 1, 64'h17);
        t = abc; t[1]  = 32'h1;        tbl[3] = mk(t, 15, 1, 0, 1, 64'd24);
        t = abc; t[15] = 32'h1C0;      tbl[4] = mk(t, 15, 1, 0, 1, 64'h1C0);
        t = abc; t[0]  = 32'h61626300; tbl[5] = mk(t, 15, 1, 0, 1, 64'd24);
        tbl[6] = mk(abc, 7,  1, 0, 0, 64'd0);
        tbl[7] = mk(abc, 15, 0, 3, 1, 64'd24);
        tbl[8] = mk(abc, 16, 1, 0, 0, 64'd0);
        tbl[9] = mk(abc, 15, 0, 3, 1, 64'd24);

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        #1;
        check("release_in_ready_low", bus.in_ready, 0);
        @(posedge clk);
        #1;
        check("release_in_ready_high", bus.in_ready, 1);

        rmode = 0;
        for (int i = 0; i < 10; i++)
            run_block($sformatf("vec%0d", i), tbl[i].w, tbl[i].last_at, tbl[i].exp_err,
                      tbl[i].exp_n, tbl[i].chk_len, tbl[i].exp_len, 1'b0);

        // Longest message with downstream ready toggling every cycle.
        for (int k = 0; k < 64; k++) b[k] = 8'h00;
        for (int k = 0; k < 55; k++) b[k] = 8'($urandom);
        b[55] = 8'h80;
        for (int i = 0; i < 16; i++) t[i] = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
        t[14] = 32'h0;
        t[15] = 32'd440;
        rmode = 1;
        run_block("max55", t, 15, 0, 55, 1, 64'd440, 1'b0);
        rmode = 0;

        for (int r = 0; r < 30; r++) begin
            n = $urandom_range(0, 55);
            for (int k = 0; k < 64; k++) b[k] = 8'h00;
            for (int k = 0; k < n; k++) b[k] = 8'($urandom);
            b[n]    = 8'h80;
            L       = 64'(n * 8);
            last_at = 15;
            c       = $urandom_range(0, 7);
            case (c)
                0: if (n < 55) b[$urandom_range(n + 1, 55)] = 8'($urandom_range(1, 255));
                   else b[55] = 8'h00;
                1: L = L + 64'($urandom_range(1, 7));
                2: L = 64'(448 + 8 * $urandom_range(0, 20));
                3: last_at = $urandom_range(0, 14);
                4: last_at = 16;
                default: ;
            endcase
            for (int i = 0; i < 16; i++) t[i] = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
            t[14] = L[63:32];
            t[15] = L[31:0];
            model(t, last_at, er, m);
            rmode = $urandom_range(0, 2);
            run_block($sformatf("rand%0d", r), t, last_at, er, m, last_at == 15, L, 1'b1);
        end

        // Reset while stalled in the byte-output phase.
        rmode = 3;
        @(posedge clk);
        #1;
        send_words(abc, 15, 1'b0);
        g = 0;
        while (!bus.out_valid && g < 20) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("rst_emit_reached", bus.out_valid, 1);
        d0  = done_cnt;
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_ready_low", bus.in_ready, 0);
        @(posedge clk);
        #1;
        check("rst_mid_ready_high", bus.in_ready, 1);
        check("rst_mid_no_done", done_cnt, d0);
        rmode = 0;
        run_block("post_rst", abc, 15, 0, 3, 1, 64'd24, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
